// File: rtl/dda_ray_packer.sv
// dda_ray_packer: transmit end of the DDA ray stream. Saturates and packs each
// accepted ray into a 38-bit word, buffers it in a small circular FIFO and
// drives a valid/ready/last stream with frame-done and column-order flags.
module dda_ray_packer #(
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 180,
    parameter int DEPTH         = 4
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic        ray_valid_in,
    output logic        ray_ready_out,
    input  logic [8:0]  ray_hcount_in,
    input  logic [9:0]  ray_line_height_in,
    input  logic        ray_wall_type_in,
    input  logic [3:0]  ray_map_data_in,
    input  logic [15:0] ray_wall_x_in,
    output logic        dda_fifo_tvalid_out,
    input  logic        dda_fifo_tready_in,
    output logic [37:0] dda_fifo_tdata_out,
    output logic        dda_fifo_tlast_out,
    output logic        frame_done_out,
    output logic        seq_error_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);
    localparam logic [8:0]    LAST_COL = 9'(SCREEN_WIDTH - 1);
    localparam logic [9:0]    LH_MAX   = 10'(SCREEN_HEIGHT);

    // One FIFO slot: packed word plus its end-of-frame marker.
    typedef struct packed {
        logic        last;
        logic [37:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [CW-1:0] rd_ptr;
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [8:0]    expected_col;
    logic          push;
    logic          pop;
    logic          xfer;
    logic          in_last;
    logic [7:0]    lh8;
    entry_t        in_entry;

    // Handshake qualifiers and the saturated, packed form of the incoming ray.
    always_comb begin
        ray_ready_out = (count < DEPTH_C);
        push          = ray_valid_in && ray_ready_out;
        xfer          = dda_fifo_tvalid_out && dda_fifo_tready_in;
        pop           = (!dda_fifo_tvalid_out || xfer) && (count != '0);
        in_last       = (ray_hcount_in == LAST_COL);
        lh8           = (ray_line_height_in > LH_MAX) ? LH_MAX[7:0] : ray_line_height_in[7:0];
        in_entry.last = in_last;
        in_entry.data = {ray_hcount_in, lh8, ray_wall_type_in, ray_map_data_in, ray_wall_x_in};
    end

    // Storage write port.
    // NOTE: the storage array is deliberately not reset; count and pointers
    // define which slots are live, so stale contents are never presented.
    always_ff @(posedge pixel_clk_in) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_entry;
        end
    end

    // Circular-buffer pointers (wrap at DEPTH) and occupancy count.
    always_ff @(posedge pixel_clk_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + CW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + CW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Output register: reload from the FIFO head when free, hold under backpressure.
    always_ff @(posedge pixel_clk_in) begin
        if (!rst_in) begin
            dda_fifo_tvalid_out <= 1'b0;
            dda_fifo_tdata_out  <= '0;
            dda_fifo_tlast_out  <= 1'b0;
        end else if (pop) begin
            dda_fifo_tvalid_out <= 1'b1;
            dda_fifo_tdata_out  <= mem[rd_ptr[AW-1:0]].data;
            dda_fifo_tlast_out  <= mem[rd_ptr[AW-1:0]].last;
        end else if (xfer) begin
            dda_fifo_tvalid_out <= 1'b0;
        end
    end

    // Frame-done strobe: one cycle after the last column leaves the packer.
    always_ff @(posedge pixel_clk_in) begin
        if (!rst_in) begin
            frame_done_out <= 1'b0;
        end else begin
            frame_done_out <= xfer && dda_fifo_tlast_out;
        end
    end

    // Column-order tracking; the expected column resyncs to whatever arrived.
    always_ff @(posedge pixel_clk_in) begin
        if (!rst_in) begin
            expected_col  <= '0;
            seq_error_out <= 1'b0;
        end else if (push) begin
            if (ray_hcount_in != expected_col) begin
                seq_error_out <= 1'b1;
            end
            expected_col <= in_last ? 9'd0 : ray_hcount_in + 9'd1;
        end
    end

endmodule

// File: tb/tb_dda_ray_packer.sv
// Self-checking bench for dda_ray_packer. A queue-based model tracks every
// accepted ray until it leaves the stream; each task checks one feature.
module tb_dda_ray_packer;
    localparam int SW    = 320;
    localparam int SH    = 180;
    localparam int DEPTH = 4;

    logic        pixel_clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        ray_valid_in = 1'b0;
    logic        ray_ready_out;
    logic [8:0]  ray_hcount_in = '0;
    logic [9:0]  ray_line_height_in = '0;
    logic        ray_wall_type_in = 1'b0;
    logic [3:0]  ray_map_data_in = '0;
    logic [15:0] ray_wall_x_in = '0;
    logic        dda_fifo_tvalid_out;
    logic        dda_fifo_tready_in = 1'b0;
    logic [37:0] dda_fifo_tdata_out;
    logic        dda_fifo_tlast_out;
    logic        frame_done_out;
    logic        seq_error_out;

    dda_ray_packer #(.SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .DEPTH(DEPTH)) dut (
        .pixel_clk_in       (pixel_clk_in),
        .rst_in             (rst_in),
        .ray_valid_in       (ray_valid_in),
        .ray_ready_out      (ray_ready_out),
        .ray_hcount_in      (ray_hcount_in),
        .ray_line_height_in (ray_line_height_in),
        .ray_wall_type_in   (ray_wall_type_in),
        .ray_map_data_in    (ray_map_data_in),
        .ray_wall_x_in      (ray_wall_x_in),
        .dda_fifo_tvalid_out(dda_fifo_tvalid_out),
        .dda_fifo_tready_in (dda_fifo_tready_in),
        .dda_fifo_tdata_out (dda_fifo_tdata_out),
        .dda_fifo_tlast_out (dda_fifo_tlast_out),
        .frame_done_out     (frame_done_out),
        .seq_error_out      (seq_error_out)
    );

    always #5 pixel_clk_in = ~pixel_clk_in;

    // Reference model: every accepted ray in flight, oldest first.
    typedef struct {
        logic [37:0] word;
        logic        last;
        int          acc_edge;
    } exp_t;

    exp_t mq[$];
    int   cyc = 0;
    int   m_col = 0;
    bit   m_seq = 1'b0;
    bit   m_fd = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Values sampled from the DUT and predicted by the model for the current cycle.
    logic        o_ready, o_tvalid, o_tlast, o_fd, o_seq;
    logic [37:0] o_tdata;
    bit          e_ready, e_tvalid, e_last, e_fd, e_seq;
    logic [37:0] e_data;

    function automatic logic [37:0] model_word(int hc, int lh, int wt, int mp, int wx);
        int lh_sat;
        lh_sat = (lh > SH) ? SH : lh;
        return {9'(hc), 8'(lh_sat), 1'(wt), 4'(mp), 16'(wx)};
    endfunction

    task automatic drive_ray(int hc, int lh, int wt, int mp, int wx);
        ray_valid_in       = 1'b1;
        ray_hcount_in      = 9'(hc);
        ray_line_height_in = 10'(lh);
        ray_wall_type_in   = 1'(wt);
        ray_map_data_in    = 4'(mp);
        ray_wall_x_in      = 16'(wx);
    endtask

    task automatic drive_idle();
        ray_valid_in = 1'b0;
    endtask

    // One clock: sample at the falling edge, predict, advance the model across
    // the next rising edge, then return just after it.
    task automatic tick();
        bit t_xfer;
        @(negedge pixel_clk_in);
        o_ready  = ray_ready_out;
        o_tvalid = dda_fifo_tvalid_out;
        o_tdata  = dda_fifo_tdata_out;
        o_tlast  = dda_fifo_tlast_out;
        o_fd     = frame_done_out;
        o_seq    = seq_error_out;
        e_ready  = (mq.size() < DEPTH + 1);
        e_tvalid = 1'b0;
        e_data   = '0;
        e_last   = 1'b0;
        if (mq.size() > 0) begin
            e_tvalid = (mq[0].acc_edge < cyc);
            e_data   = mq[0].word;
            e_last   = mq[0].last;
        end
        e_fd  = m_fd;
        e_seq = m_seq;
        if (!rst_in) begin
            mq.delete();
            m_col = 0;
            m_seq = 1'b0;
            m_fd  = 1'b0;
        end else begin
            t_xfer = e_tvalid && dda_fifo_tready_in;
            m_fd   = t_xfer && e_last;
            if (t_xfer) void'(mq.pop_front());
            if (ray_valid_in && e_ready) begin
                exp_t ent;
                if (int'(ray_hcount_in) != m_col) m_seq = 1'b1;
                m_col = (int'(ray_hcount_in) == SW - 1) ? 0 : int'(ray_hcount_in) + 1;
                ent.word = model_word(int'(ray_hcount_in), int'(ray_line_height_in),
                                      int'(ray_wall_type_in), int'(ray_map_data_in),
                                      int'(ray_wall_x_in));
                ent.last = (int'(ray_hcount_in) == SW - 1);
                ent.acc_edge = cyc + 1;
                mq.push_back(ent);
            end
        end
        @(posedge pixel_clk_in);
        cyc++;
        #1;
    endtask

    task automatic apply_reset();
        rst_in = 1'b0;
        drive_idle();
        tick();
        tick();
        rst_in = 1'b1;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        dda_fifo_tready_in = 1'b1;
        drive_ray(7, 50, 0, 1, 16'h1234);
        tick(); tick(); tick();
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", o_tvalid); end
        checks++; if (o_tdata !== 38'd0) begin errors++; $display("FAIL reset_tdata got %h want 0", o_tdata); end
        checks++; if (o_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", o_tlast); end
        checks++; if (o_fd !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", o_fd); end
        checks++; if (o_seq !== 1'b0) begin errors++; $display("FAIL reset_seq_error got %b want 0", o_seq); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", o_ready); end
        rst_in = 1'b1;
        drive_idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL reset_ray_leaked cycle %0d got tvalid %b want 0", i, o_tvalid); end
        end
    endtask

    task automatic test_single();
        logic [37:0] want;
        want = {9'd5, 8'd100, 1'b1, 4'd3, 16'hABCD};
        apply_reset();
        dda_fifo_tready_in = 1'b1;
        drive_ray(5, 100, 1, 3, 16'hABCD);
        tick();
        drive_idle();
        tick();
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL single_latency_early got tvalid %b want 0", o_tvalid); end
        tick();
        checks++; if (o_tvalid !== 1'b1) begin errors++; $display("FAIL single_tvalid got %b want 1", o_tvalid); end
        checks++; if (o_tdata !== want) begin errors++; $display("FAIL single_tdata got %h want %h", o_tdata, want); end
        checks++; if (o_tlast !== 1'b0) begin errors++; $display("FAIL single_tlast got %b want 0", o_tlast); end
        checks++; if (o_seq !== 1'b1) begin errors++; $display("FAIL single_seq_error got %b want 1", o_seq); end
        tick();
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL single_drain got tvalid %b want 0", o_tvalid); end
    endtask

    task automatic test_saturation();
        int lhs[6] = '{700, 180, 179, 181, 0, 1023};
        int want[6] = '{180, 180, 179, 180, 0, 180};
        logic [7:0] got[$];
        apply_reset();
        dda_fifo_tready_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 6) drive_ray(i, lhs[i], 0, 0, 0);
            else drive_idle();
            tick();
            if (o_tvalid) got.push_back(o_tdata[28:21]);
        end
        checks++; if (got.size() != 6) begin errors++; $display("FAIL sat_count got %0d want 6", got.size()); end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            checks++; if (int'(got[i]) != want[i]) begin errors++; $display("FAIL sat_lh in %0d got %0d want %0d", lhs[i], got[i], want[i]); end
        end
    endtask

    task automatic test_full_frame();
        int words = 0, lasts = 0, fds = 0;
        apply_reset();
        dda_fifo_tready_in = 1'b1;
        for (int i = 0; i < 336; i++) begin
            if (i < 330) drive_ray(i % SW, $urandom_range(0, 1023), $urandom_range(0, 1),
                                   $urandom_range(0, 15), $urandom_range(0, 65535));
            else drive_idle();
            tick();
            if (i < 330) begin
                checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL frame_ready at %0d got %b want 1", i, o_ready); end
            end
            checks++; if (o_tvalid !== e_tvalid) begin errors++; $display("FAIL frame_tvalid at %0d got %b want %b", i, o_tvalid, e_tvalid); end
            if (o_tvalid && e_tvalid) begin
                words++;
                checks++; if (o_tdata !== e_data) begin errors++; $display("FAIL frame_tdata at %0d got %h want %h", i, o_tdata, e_data); end
                checks++; if (o_tlast !== e_last) begin errors++; $display("FAIL frame_tlast at %0d got %b want %b", i, o_tlast, e_last); end
                if (o_tlast) lasts++;
            end
            if (o_fd === 1'b1) fds++;
        end
        checks++; if (words != 330) begin errors++; $display("FAIL frame_words got %0d want 330", words); end
        checks++; if (lasts != 1) begin errors++; $display("FAIL frame_tlast_count got %0d want 1", lasts); end
        checks++; if (fds != 1) begin errors++; $display("FAIL frame_done_count got %0d want 1", fds); end
        checks++; if (o_seq !== 1'b0) begin errors++; $display("FAIL frame_seq_error got %b want 0", o_seq); end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int got[$];
        apply_reset();
        dda_fifo_tready_in = 1'b0;
        for (int t = 0; t < 10; t++) begin
            if (idx < 8) drive_ray(idx, 40 + idx, 0, 0, idx);
            else drive_idle();
            tick();
            if (ray_valid_in && o_ready) idx++;
        end
        checks++; if (idx != DEPTH + 1) begin errors++; $display("FAIL bp_accepts got %0d want %0d", idx, DEPTH + 1); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b want 0", o_ready); end
        checks++; if (o_tvalid !== 1'b1) begin errors++; $display("FAIL bp_tvalid got %b want 1", o_tvalid); end
        checks++; if (o_tdata[37:29] !== 9'd0) begin errors++; $display("FAIL bp_hold_word got %0d want 0", o_tdata[37:29]); end
        dda_fifo_tready_in = 1'b1;
        for (int t = 0; t < 30; t++) begin
            if (idx < 8) drive_ray(idx, 40 + idx, 0, 0, idx);
            else drive_idle();
            tick();
            if (ray_valid_in && o_ready) idx++;
            if (o_tvalid) got.push_back(int'(o_tdata[37:29]));
        end
        checks++; if (idx != 8) begin errors++; $display("FAIL bp_total_accepts got %0d want 8", idx); end
        checks++; if (got.size() != 8) begin errors++; $display("FAIL bp_words got %0d want 8", got.size()); end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            checks++; if (got[i] != i) begin errors++; $display("FAIL bp_order pos %0d got %0d want %0d", i, got[i], i); end
        end
    endtask

    task automatic test_order_error();
        apply_reset();
        dda_fifo_tready_in = 1'b1;
        drive_ray(0, 10, 0, 0, 0); tick();
        drive_ray(1, 10, 0, 0, 0); tick();
        drive_ray(3, 10, 0, 0, 0); tick();
        checks++; if (o_seq !== 1'b0) begin errors++; $display("FAIL order_before_gap got %b want 0", o_seq); end
        drive_ray(4, 10, 0, 0, 0); tick();
        checks++; if (o_seq !== 1'b1) begin errors++; $display("FAIL order_after_gap got %b want 1", o_seq); end
        drive_idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (o_seq !== 1'b1) begin errors++; $display("FAIL order_sticky cycle %0d got %b want 1", i, o_seq); end
        end
    endtask

    task automatic test_random();
        bit p_tvalid = 1'b0, p_tready = 1'b0;
        logic [37:0] p_data = '0;
        int hc;
        apply_reset();
        for (int i = 0; i < 2000; i++) begin
            hc = ($urandom_range(0, 49) == 0) ? $urandom_range(0, SW - 1) : m_col;
            if ($urandom_range(0, 9) < 7)
                drive_ray(hc, ($urandom_range(0, 3) == 0) ? $urandom_range(175, 185) : $urandom_range(0, 1023),
                          $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 65535));
            else
                drive_idle();
            dda_fifo_tready_in = ($urandom_range(0, 9) < 6);
            tick();
            checks++; if (o_ready !== e_ready) begin errors++; $display("FAIL rnd_ready at %0d got %b want %b", i, o_ready, e_ready); end
            checks++; if (o_tvalid !== e_tvalid) begin errors++; $display("FAIL rnd_tvalid at %0d got %b want %b", i, o_tvalid, e_tvalid); end
            checks++; if (o_fd !== e_fd) begin errors++; $display("FAIL rnd_frame_done at %0d got %b want %b", i, o_fd, e_fd); end
            checks++; if (o_seq !== e_seq) begin errors++; $display("FAIL rnd_seq_error at %0d got %b want %b", i, o_seq, e_seq); end
            if (o_tvalid && e_tvalid) begin
                checks++; if (o_tdata !== e_data) begin errors++; $display("FAIL rnd_tdata at %0d got %h want %h", i, o_tdata, e_data); end
                checks++; if (o_tlast !== e_last) begin errors++; $display("FAIL rnd_tlast at %0d got %b want %b", i, o_tlast, e_last); end
            end
            if (p_tvalid && !p_tready) begin
                checks++; if (o_tvalid !== 1'b1 || o_tdata !== p_data) begin errors++; $display("FAIL rnd_stall_hold at %0d got %b/%h want 1/%h", i, o_tvalid, o_tdata, p_data); end
            end
            p_tvalid = o_tvalid;
            p_tready = dda_fifo_tready_in;
            p_data   = o_tdata;
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        dda_fifo_tready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_ray(i, 20, 0, 0, i);
            tick();
        end
        drive_idle();
        tick();
        checks++; if (o_tvalid !== 1'b1) begin errors++; $display("FAIL mid_pre_tvalid got %b want 1", o_tvalid); end
        rst_in = 1'b0;
        drive_ray(9, 20, 0, 0, 9);
        tick();
        rst_in = 1'b1;
        drive_idle();
        dda_fifo_tready_in = 1'b1;
        tick();
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL mid_tvalid got %b want 0", o_tvalid); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", o_ready); end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL mid_stale cycle %0d got tvalid %b want 0", i, o_tvalid); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_saturation();
        test_full_frame();
        test_backpressure();
        test_order_error();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dda_ray_packer.md
# dda_ray_packer

Transmit end of the DDA-to-transformation ray stream. Accepts one ray result per handshake from the DDA stage, saturates and packs it into the 38-bit stream word, buffers it in a small FIFO, and drives a valid/ready/last stream into the DDA FIFO consumed by the column flattener. It marks the last column of every frame with `tlast`, pulses a frame-done strobe, and flags out-of-order columns.

## Interface
- `SCREEN_WIDTH`, 320: columns per frame; `hcount` range is 0..SCREEN_WIDTH-1.
- `SCREEN_HEIGHT`, 180: rows per frame; the line-height saturation ceiling.
- `DEPTH`, 4: FIFO entries; must be a power of two, minimum 2.

Ports:
- `pixel_clk_in`  in  1  pixel clock; the only clock.
- `rst_in`  in  1  reset; synchronous, active-low.
- `ray_valid_in`  in  1  DDA has a ray result.
- `ray_ready_out`  out  1  packer accepts a ray this cycle.
- `ray_hcount_in`  in  9  screen column of the ray.
- `ray_line_height_in`  in  10  unsaturated wall line height in rows.
- `ray_wall_type_in`  in  1  0 = X-side hit, 1 = Y-side hit.
- `ray_map_data_in`  in  4  map cell value at the hit.
- `ray_wall_x_in`  in  16  fractional hit position along the wall.
- `dda_fifo_tvalid_out`  out  1  stream word valid.
- `dda_fifo_tready_in`  in  1  downstream accepts the word.
- `dda_fifo_tdata_out`  out  38  packed ray word.
- `dda_fifo_tlast_out`  out  1  word is the frame's last column.
- `frame_done_out`  out  1  one-cycle pulse when a `tlast` word is accepted.
- `seq_error_out`  out  1  sticky column-order error.

## Operation
- **Input acceptance.** A ray is accepted on any cycle where `ray_valid_in` and `ray_ready_out` are both 1.
- **Ready rule.** `ray_ready_out` = (FIFO count < DEPTH). It depends only on registered count and has no combinational path from `dda_fifo_tready_in`.
- **Line-height saturation.**
  - `lh8 = (ray_line_height_in > SCREEN_HEIGHT) ? SCREEN_HEIGHT : ray_line_height_in[7:0]`.
  - A value equal to SCREEN_HEIGHT passes unchanged.
- **Packing.** On accept, the FIFO writes `{hcount[8:0], lh8[7:0], wall_type, map_data[3:0], wall_x[15:0]}` into bits [37:29], [28:21], [20], [19:16], [15:0]. The consumer halves the line height; the packer does not.
- **Last flag.** `last = (ray_hcount_in == SCREEN_WIDTH-1)`. It is stored alongside each entry as a 39th bit and presented on `dda_fifo_tlast_out` with its word.
- **FIFO.** Circular buffer with read pointer, write pointer and count, each log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- **Output register.**
  - When `tvalid` is 0, or a transfer happens (`tvalid & tready`), and the FIFO is non-empty, load the head entry, set `tvalid` = 1 and pop.
  - When a transfer happens with the FIFO empty, `tvalid` goes to 0.
  - `tdata`/`tlast` are held stable while `tvalid=1` and `tready=0`.
- **Sequencing.** An `expected` register holds the next column (reset 0).
  - On each accept: if `ray_hcount_in != expected`, set `seq_error_out` = 1; it stays set until reset.
  - Then set `expected = (hcount == SCREEN_WIDTH-1) ? 0 : hcount+1`. This resyncs to the received column.
- **Frame done.** `frame_done_out` = 1 for exactly the cycle after a transfer with `tlast` = 1; otherwise 0.

## Timing
- **Reset values.** While `rst_in` = 0 at a clock edge:
  - `dda_fifo_tvalid_out`=0, `dda_fifo_tdata_out`=0, `dda_fifo_tlast_out`=0, `frame_done_out`=0, `seq_error_out`=0.
  - count=0, both pointers=0, expected=0.
  - `ray_ready_out` therefore reads 1 after reset.
- **Reset mid-operation.** Buffered words are discarded and no partial handshake completes. The ray offered in the reset cycle is not accepted.
- **Latency.** A ray accepted at edge N into an empty packer with `tvalid`=0 appears on `dda_fifo_tvalid_out`/`tdata` after edge N+1 (two-edge write-then-load).
- **Throughput.** One word per cycle sustained when `tready` is held at 1.
- **Full FIFO.** With count=DEPTH, `ray_ready_out`=0 and no write occurs, even if a pop happens the same cycle. Ready returns the cycle after count drops.
- **Empty FIFO.** With count=0 and a transfer, `tvalid` drops the next cycle. No underflow pop.
- **Simultaneous push and pop.** Count is unchanged and the pointers both advance.
- **Capacity.** Total buffering is DEPTH FIFO entries plus 1 output-register word.
- **Protocol rule.** `tvalid` never deasserts without a transfer.

## Test plan
- **Single ray.** After reset, send hcount=5, lh=100, wall_type=1, map=3, wall_x=0xABCD with `tready`=1 → two edges later `tvalid`=1 and `tdata`={5,100,1,3,0xABCD}; `tlast`=0; `seq_error_out`=1 (expected 0).
- **Saturation.** lh_in=700 → tdata[28:21]=180; lh_in=180 → 180; lh_in=179 → 179.
- **Full frame.** hcount 0..319 streamed with `tready`=1 → 320 words in order; `tlast`=1 only on hcount 319; `frame_done_out` pulses once; `seq_error_out` stays 0. A second frame starting at hcount 0 also gives no error.
- **Backpressure.** Hold `tready`=0 and offer 8 rays → `ray_ready_out` falls after DEPTH+1=5 accepts; `tdata` holds word 0. Release `tready` → words 0..4 emerge in order, then the remaining 3 are accepted.
- **Order error.** Send hcount 0, 1, 3 → `seq_error_out` rises after the accept of 3 and stays 1. Next expected is 4, so a following hcount 4 gives no new event.
- **Reset mid-frame.** Assert `rst_in`=0 with 3 words buffered and `tvalid`=1 → next cycle `tvalid`=0, `ray_ready_out`=1, and no stale word is emitted after reset release.
